// File: rtl/shifter_seq_if.sv
// Handshake bundle for shifter_seq: command channel in, result/flags channel out.
interface shifter_seq_if #(
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(WIDTH) + 1
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] i;
   logic [AW-1:0]    amt;
   logic             lr;
   logic             la;
   logic             rot;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             ovf;

   modport master (
      output in_valid, i, amt, lr, la, rot, out_ready,
      input  in_ready, out_valid, result, carry, zero, ovf
   );

   modport slave (
      input  in_valid, i, amt, lr, la, rot, out_ready,
      output in_ready, out_valid, result, carry, zero, ovf
   );
endinterface

// File: rtl/shifter_seq.sv
// Multi-cycle shifter/rotator: one bit position per clock, valid/ready on both
// sides, with carry, zero and sticky arithmetic-overflow flags.
module shifter_seq #(
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(WIDTH) + 1
) (
   input logic         clk,
   input logic         rst_n,
   shifter_seq_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] r, rNext;
   logic [AW-1:0]    cnt, nEff;
   logic             carryQ, ovfQ, outBit;
   logic             lrQ, laQ, rotQ;
   logic             accept;

   assign accept = bus.in_valid && (state == IDLE);

   // Rotates wrap modulo WIDTH; shifts saturate at WIDTH (counter holds WIDTH without wrap).
   always_comb begin
      nEff = '0;
      if (bus.rot)
         nEff = {1'b0, bus.amt[AW-2:0]};
      else if (bus.amt >= AW'(WIDTH))
         nEff = AW'(WIDTH);
      else
         nEff = bus.amt;
   end

   always_comb begin
      rNext  = r;
      outBit = 1'b0;
      if (!lrQ) begin
         outBit = r[WIDTH-1];
         rNext  = {r[WIDTH-2:0], rotQ & r[WIDTH-1]};
      end else begin
         outBit = r[0];
         rNext  = {rotQ ? r[0] : (laQ & r[WIDTH-1]), r[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         r      <= '0;
         cnt    <= '0;
         carryQ <= 1'b0;
         ovfQ   <= 1'b0;
         lrQ    <= 1'b0;
         laQ    <= 1'b0;
         rotQ   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  r      <= bus.i;
                  lrQ    <= bus.lr;
                  laQ    <= bus.la;
                  rotQ   <= bus.rot;
                  carryQ <= 1'b0;
                  ovfQ   <= 1'b0;
                  cnt    <= nEff;
                  state  <= (nEff == '0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               r      <= rNext;
               carryQ <= outBit;
               // Overflow only tracks arithmetic left shifts; sticky across steps.
               if (!lrQ && laQ && !rotQ && (rNext[WIDTH-1] != r[WIDTH-1]))
                  ovfQ <= 1'b1;
               cnt <= cnt - 1'b1;
               if (cnt == AW'(1))
                  state <= DONE;
            end
            DONE: begin
               if (bus.out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = r;
   assign bus.carry     = carryQ;
   assign bus.ovf       = ovfQ;
   assign bus.zero      = (state == DONE) && (r == '0);
endmodule

// File: tb/tb_shifter_seq.sv
// Directed bench for shifter_seq with an arithmetic reference model and a
// per-cycle output compare process.
module tb_shifter_seq;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total  = 0;

   logic [W-1:0] expR;
   logic         expC, expO;

   shifter_seq_if #(.WIDTH(W)) bus ();
   shifter_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic int effN(input int amt, input bit rot);
      if (rot) return amt % W;
      return (amt > W) ? W : amt;
   endfunction

   // Returns {result, carry, ovf} computed directly from the mode definitions.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input int amt,
                                          input bit lr, input bit la, input bit rot);
      int           n;
      logic [W-1:0] res;
      logic         c, o;
      logic [2*W:0] top, mask;
      n = effN(amt, rot);
      res = x; c = 1'b0; o = 1'b0;
      if (n != 0) begin
         if (rot && !lr) begin
            res = (x << n) | (x >> (W - n)); c = res[0];
         end else if (rot) begin
            res = (x >> n) | (x << (W - n)); c = res[W-1];
         end else if (!lr) begin
            res = x << n; c = x[W-n];
            if (la) begin
               // Sign changes somewhere iff the top n+1 bits of {x,0...} are not uniform.
               top  = {1'b0, x, {W{1'b0}}} >> (2*W - 1 - n);
               mask = (1 << (n + 1)) - 1;
               o = !((top == 0) || (top == mask));
            end
         end else if (la) begin
            res = $signed(x) >>> n; c = x[n-1];
         end else begin
            res = x >> n; c = x[n-1];
         end
      end
      return {res, c, o};
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid) begin
            chk("result", bus.result, expR);
            chk("carry", bus.carry, expC);
            chk("ovf", bus.ovf, expO);
            chk("zero", bus.zero, (expR == '0));
            chk("in_ready_done", bus.in_ready, 1'b0);
         end else begin
            chk("zero_idle", bus.zero, 1'b0);
         end
      end
   end

   // Issue one command, check latency, optionally stall in DONE, then release.
   task automatic run(input logic [W-1:0] x, input int amt, input bit lr, input bit la,
                      input bit rot, input int hold);
      int k;
      {expR, expC, expO} = model(x, amt, lr, la, rot);
      @(negedge clk);
      chk("in_ready_idle", bus.in_ready, 1'b1);
      bus.i = x; bus.amt = amt[3:0]; bus.lr = lr; bus.la = la; bus.rot = rot;
      bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.i = W'($urandom); bus.amt = 4'($urandom);
      k = 0;
      while (k < 40) begin
         @(negedge clk); k++;
         if (bus.out_valid) break;
      end
      chk("latency", k, effN(amt, rot) + 1);
      if (!bus.out_valid) return;
      repeat (hold) begin
         bus.in_valid = 1'($urandom); bus.i = W'($urandom);
         @(negedge clk);
         chk("bp_in_ready", bus.in_ready, 1'b0);
         chk("bp_out_valid", bus.out_valid, 1'b1);
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("release_out_valid", bus.out_valid, 1'b0);
      chk("release_in_ready", bus.in_ready, 1'b1);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.i = '0; bus.amt = '0;
      bus.lr = 1'b0; bus.la = 1'b0; bus.rot = 1'b0;
      expR = '0; expC = 1'b0; expO = 1'b0;
      #12;
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_result", bus.result, 8'h00);
      chk("rst_carry", bus.carry, 1'b0);
      chk("rst_zero", bus.zero, 1'b0);
      chk("rst_ovf", bus.ovf, 1'b0);

      chk("pin_asl", model(8'h96, 3, 0, 1, 0), {8'hB0, 1'b0, 1'b1});
      chk("pin_asr", model(8'h96, 2, 1, 1, 0), {8'hE5, 1'b1, 1'b0});
      chk("pin_lsr_sat", model(8'h96, 12, 1, 0, 0), {8'h00, 1'b1, 1'b0});
      chk("pin_asr_sat", model(8'h96, 15, 1, 1, 0), {8'hFF, 1'b1, 1'b0});
      chk("pin_ror", model(8'h96, 11, 1, 0, 1), {8'hD2, 1'b1, 1'b0});
      chk("pin_rol0", model(8'h96, 8, 0, 0, 1), {8'h96, 1'b0, 1'b0});
      chk("pin_asl_noovf", model(8'hE1, 2, 0, 1, 0), {8'h84, 1'b1, 1'b0});

      @(negedge clk); rst_n = 1'b1;

      run(8'h96, 3, 0, 1, 0, 0);   // ASL
      run(8'h96, 2, 1, 1, 0, 0);   // ASR
      run(8'h96, 12, 1, 0, 0, 0);  // LSR saturating
      run(8'h96, 15, 1, 1, 0, 0);  // ASR saturating
      run(8'h96, 11, 1, 0, 1, 0);  // ROR n=3
      run(8'h96, 8, 0, 0, 1, 0);   // ROL n=0
      run(8'hE1, 2, 0, 1, 0, 0);   // ASL, no overflow
      run(8'h01, 8, 0, 0, 0, 0);   // LSL by WIDTH
      run(8'hFF, 8, 0, 1, 0, 0);   // ASL by WIDTH
      run(8'h3C, 0, 0, 0, 0, 0);   // shift by zero
      run(8'h5A, 5, 0, 0, 1, 0);   // ROL n=5
      run(8'h96, 3, 0, 0, 0, 5);   // LSL with backpressure

      // Reset during the second SHIFT cycle of a 5-step command.
      {expR, expC, expO} = model(8'h96, 5, 0, 0, 0);
      @(negedge clk);
      bus.i = 8'h96; bus.amt = 4'd5; bus.lr = 1'b0; bus.la = 1'b0; bus.rot = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", bus.out_valid, 1'b0);
      chk("midrst_result", bus.result, 8'h00);
      chk("midrst_in_ready", bus.in_ready, 1'b1);
      chk("midrst_ovf", bus.ovf, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         chk("post_rst_no_result", bus.out_valid, 1'b0);
      end
      run(8'h96, 5, 1, 1, 0, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/shifter_seq.md
# shifter_seq

Parametrised, multi-cycle successor to the team's 8-bit single-step shifter. It shifts or rotates a WIDTH-bit operand by a variable amount, one bit position per clock. Operands arrive and results leave on valid/ready handshakes. It also produces carry, zero and arithmetic-overflow flags. It sits in the ALU datapath, behind operand select and ahead of the flag/result writeback.

## Interface
- WIDTH, default 8: operand width. Must be a power of two and at least 4.
- AW, default $clog2(WIDTH)+1: width of the shift-amount field. Amounts range over 0..2*WIDTH-1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  an operand and command are presented.
- in_ready  out  1  block can accept; high only in IDLE.
- i  in  WIDTH  operand.
- amt  in  AW  shift/rotate amount.
- lr  in  1  direction: 0 = left, 1 = right.
- la  in  1  shift type: 0 = logical, 1 = arithmetic. Ignored when rot=1.
- rot  in  1  0 = shift, 1 = rotate.
- out_valid  out  1  result and flags are valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  shifted or rotated value.
- carry  out  1  last bit shifted out, or last bit wrapped (rotate); 0 if the effective count is 0.
- zero  out  1  out_valid & (result == 0), combinational.
- ovf  out  1  sticky. Set when the sign bit changes on any step of a left shift with la=1; 0 for all other modes.

## Operation
- Modes, per step: LSL/ASL {r[W-2:0],0}; LSR {0,r[W-1:1]}; ASR {r[W-1],r[W-1:1]}; ROL {r[W-2:0],r[W-1]}; ROR {r[0],r[W-1:1]}.
- Effective count n:
  - rotate: amt mod WIDTH, i.e. amt[AW-2:0].
  - shift: min(amt, WIDTH). Amounts at or above WIDTH saturate: LSL/LSR give 0, ASR gives all sign bits.
- The command (i, lr, la, rot, n) is captured on the accept edge (in_valid & in_ready). Inputs are don't-care after that edge.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On accept, load r=i, clear carry and ovf, set cnt=n. Go to SHIFT if n>0, else DONE.
  - SHIFT: each edge applies one step, updates carry and ovf, and decrements cnt. When cnt reaches 0, go to DONE. in_valid is ignored.
  - DONE: out_valid=1. result, carry and ovf are held stable. On out_valid & out_ready, go to IDLE.
- No accept in the same cycle as a result handoff. in_ready is low in DONE, so the block accepts at most one command per n+2 cycles.
- The registered counter is AW bits wide; it must not wrap when n = WIDTH.

## Timing
- Reset (asynchronous, takes effect immediately while rst_n=0):
  - state=IDLE, so in_ready=1.
  - out_valid=0, result=0, carry=0, zero=0, ovf=0.
- Reset mid-SHIFT or mid-DONE: the command in flight is discarded and no result is produced.
- Latency: with accept at edge E0, out_valid is first sampled high at edge E0+n+1. For n=0 this is E0+1.
- Backpressure: while out_ready=0 in DONE, every output stays constant for an unbounded time.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from inputs to them.
- zero is the only combinational output, and it depends only on registered values.

## Test plan
- LSL, la=1, WIDTH=8, i=0x96, amt=3 -> result=0xB0, carry=0, ovf=1, zero=0; out_valid sampled high at E0+4.
- ASR, i=0x96, amt=2 -> result=0xE5, carry=1, ovf=0; out_valid at E0+3.
- LSR, i=0x96, amt=12 (saturates to 8) -> result=0x00, carry=1, zero=1; out_valid at E0+9. Then ASR, i=0x96, amt=15 -> result=0xFF, carry=1.
- ROR, i=0x96, amt=11 (n=3) -> result=0xD2, carry=1; out_valid at E0+4. Then ROL, amt=8 (n=0) -> result=0x96, carry=0; out_valid at E0+1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and i. Required: result and flags stable, in_ready=0, no new accept. Set out_ready=1: next cycle IDLE with in_ready=1.
- Drop rst_n low during the 2nd SHIFT cycle of amt=5 -> immediately out_valid=0, result=0, in_ready=1. A fresh command after release completes normally.
